// File: rtl/counter_share_ctrl.sv
// Round-robin arbiter and run sequencer that shares one sync-clear/enable up-counter
// between N_REQ requesters, each asking for a timed run of len enabled cycles.
module counter_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   len,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         cnt_val,
    output logic                     cnt_clr,
    output logic                     cnt_en,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [N_REQ-1:0]         done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   len_q_r;
    logic [N_REQ-1:0]   grant_r;
    logic [IDX_W-1:0]   pick_s;
    logic               pick_vld_s;
    logic [IDX_W-1:0]   owner_inc_s;
    logic               at_len_s;

    // Round-robin pick: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pick_vld_s = 1'b0;
        pick_s     = '0;
        idx        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr_r) + k) % N_REQ);
            if (!pick_vld_s && req[idx]) begin
                pick_vld_s = 1'b1;
                pick_s     = idx;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    assign owner_inc_s = (owner_r == IDX_W'(N_REQ - 1)) ? '0 : owner_r + IDX_W'(1);
    assign at_len_s    = (cnt_val == len_q_r);

    // Next-state logic for the run sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = pick_vld_s ? CLEAR : IDLE;
            CLEAR:   state_s = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (at_len_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, ownership, latched length and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            len_q_r  <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (pick_vld_s) begin
                        grant_r <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
                        owner_r <= pick_s;
                        len_q_r <= len[pick_s*CNT_W +: CNT_W];
                    end else begin
                        grant_r <= '0;
                    end
                end
                CLEAR, RUN: begin
                    if (abort) begin
                        grant_r  <= '0;
                        rr_ptr_r <= owner_inc_s;
                    end else begin
                        grant_r  <= grant_r;
                    end
                end
                FIN: begin
                    grant_r  <= '0;
                    rr_ptr_r <= owner_inc_s;
                end
                default: grant_r <= '0;
            endcase
        end
    end

    // Abort gates the enable immediately so an aborted run stops where it stands.
    assign cnt_en  = (state_r == RUN) && !at_len_s && !abort;
    assign cnt_clr = (state_r == CLEAR);
    assign busy    = (state_r != IDLE);
    assign grant   = grant_r;
    assign done    = (state_r == FIN) ? grant_r : '0;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Directed bench for counter_share_ctrl with a behavioural shared counter and a
// done-pulse scoreboard.
module tb_counter_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic        abort;
    logic [3:0]  cnt_val = 4'd0;
    logic        cnt_clr;
    logic        cnt_en;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done;

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] c;
    } exp_t;
    exp_t sb_q[$];

    counter_share_ctrl #(.N_REQ(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .len(len), .abort(abort),
        .cnt_val(cnt_val), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural shared counter: sync clear, enable.
    always @(posedge clk) begin
        if (cnt_clr) cnt_val <= 4'd0;
        else if (cnt_en) cnt_val <= cnt_val + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (grant != 4'd0 && c < budget) begin
            tick();
            c++;
        end
        chk(tag, {28'd0, grant}, 32'd0);
    endtask

    // Scoreboard and invariant monitor.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("inv_grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            chk("inv_clr_en_excl", {31'd0, cnt_clr & cnt_en}, 32'd0);
            if (done != 4'd0) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_done", {28'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_done_owner", {28'd0, done}, {28'd0, e.d});
                    chk("sb_done_cnt", {28'd0, cnt_val}, {28'd0, e.c});
                end
            end
        end
    end

    initial begin
        int gap;
        reset = 1'b1; req = 4'd0; len = 16'd0; abort = 1'b0;
        tick(); tick();
        reset = 1'b0;
        mon_on = 1'b1;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clr_en", {30'd0, cnt_clr, cnt_en}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);

        // 1: requester 0, len 5; len change and req drop mid-run are ignored
        len[3:0] = 4'd5; req = 4'b0001;
        tick();
        chk("t1_grant", {28'd0, grant}, 32'h1);
        chk("t1_clr", {31'd0, cnt_clr}, 32'd1);
        sb_q.push_back('{d: 4'b0001, c: 4'd5});
        req = 4'd0; len[3:0] = 4'd2;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t1_run_en", {31'd0, cnt_en}, (i < 5) ? 32'd1 : 32'd0);
            chk("t1_run_cnt", {28'd0, cnt_val}, i);
            tick();
        end
        chk("t1_fin_done", {28'd0, done}, 32'h1);
        chk("t1_fin_grant", {28'd0, grant}, 32'h1);
        tick();
        chk("t1_idle_grant", {28'd0, grant}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // 2: requester 1, len 0
        len[7:4] = 4'd0; req = 4'b0010;
        tick();
        chk("t2_grant", {28'd0, grant}, 32'h2);
        sb_q.push_back('{d: 4'b0010, c: 4'd0});
        req = 4'd0;
        tick();
        chk("t2_run_en", {31'd0, cnt_en}, 32'd0);
        tick();
        chk("t2_done", {28'd0, done}, 32'h2);
        tick();

        // 3: all request, all len 2, starting from a fresh pointer
        reset = 1'b1; tick(); reset = 1'b0;
        len = {4'd2, 4'd2, 4'd2, 4'd2}; req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            gap = 0;
            while (grant == 4'd0 && gap < 4) begin
                tick();
                gap++;
            end
            chk("t3_grant_order", {28'd0, grant}, 32'd1 << (r % 4));
            chk("t3_gap", gap, 32'd1);
            sb_q.push_back('{d: 4'(4'b0001 << (r % 4)), c: 4'd2});
            if (r == 4) req = 4'd0;
            wait_idle("t3_run_timeout", 10);
        end

        // 4: abort after three enables, then requester 1 is next
        len[3:0] = 4'd9; len[7:4] = 4'd1; req = 4'b0001;
        tick();
        chk("t4_grant", {28'd0, grant}, 32'h1);
        tick(); tick(); tick(); tick();
        chk("t4_cnt_pre", {28'd0, cnt_val}, 32'd3);
        abort = 1'b1; req = 4'b0011;
        #1;
        chk("t4_en_gated", {31'd0, cnt_en}, 32'd0);
        tick();
        abort = 1'b0;
        chk("t4_grant_drop", {28'd0, grant}, 32'd0);
        chk("t4_cnt_hold", {28'd0, cnt_val}, 32'd3);
        chk("t4_no_done", {28'd0, done}, 32'd0);
        tick();
        chk("t4_next_grant", {28'd0, grant}, 32'h2);
        sb_q.push_back('{d: 4'b0010, c: 4'd1});
        req = 4'd0;
        wait_idle("t4_run_timeout", 10);
        tick();

        // 5: abort coincides with cnt_val reaching len
        len[11:8] = 4'd2; req = 4'b0100;
        tick();
        chk("t5_grant", {28'd0, grant}, 32'h4);
        req = 4'd0;
        tick(); tick(); tick();
        chk("t5_at_len", {28'd0, cnt_val}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_no_done", {28'd0, done}, 32'd0);
        chk("t5_grant_drop", {28'd0, grant}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        tick();

        // 6: reset during RUN, pending request restarts from requester 0
        len[15:12] = 4'd7; req = 4'b1000;
        tick();
        chk("t6_grant", {28'd0, grant}, 32'h8);
        tick(); tick();
        chk("t6_in_run", {31'd0, cnt_en}, 32'd1);
        req = 4'b0011; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_outs", {21'd0, grant, done, busy, cnt_clr, cnt_en}, 32'd0);
        tick();
        chk("t6_regrant", {28'd0, grant}, 32'h1);
        sb_q.push_back('{d: 4'b0001, c: 4'd9});
        req = 4'd0;
        wait_idle("t6_run_timeout", 20);
        tick(); tick();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
